seg_scan_ctrl: RTL and testbench

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl_pkg.sv | 20 ++
 rtl/seg_scan_ctrl_if.sv | 23 ++
 rtl/seg_scan_ctrl_seg_driver.sv | 11 +
 rtl/seg_scan_ctrl.sv | 122 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants for the multiplexed 7-segment scanner:
// segment encodings, the dark pattern and the slot FSM states.
package seg_scan_ctrl_pkg;

  typedef enum logic {
    GUARD = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low gfedcba patterns for hex digits 0..F
  localparam logic [6:0] SEG_CODE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load handshake, scan enable and display outputs of the segment scanner.
interface seg_scan_ctrl_if #(
  parameter int N_DIGITS = 4
);
  logic                    en;
  logic                    ld_valid;
  logic [4*N_DIGITS-1:0]   ld_data;
  logic [N_DIGITS-1:0]     ld_blank;
  logic                    ld_ready;
  logic [N_DIGITS-1:0]     AN;
  logic [6:0]              SEG;
  logic                    frame_start;

  modport master (
    output en, ld_valid, ld_data, ld_blank,
    input  ld_ready, AN, SEG, frame_start
  );

  modport slave (
    input  en, ld_valid, ld_data, ld_blank,
    output ld_ready, AN, SEG, frame_start
  );
endinterface

// File: rtl/seg_scan_ctrl_seg_driver.sv
// Combinational hex-to-segment decoder (active-low gfedcba).
module seg_scan_ctrl_seg_driver
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_CODE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scanner with guard blanking per digit slot and
// frame-aligned double-buffered display loads.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS  = 4,
  parameter int TICK_DIV  = 50000,
  parameter int GUARD_CYC = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seg_scan_ctrl_if.slave bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [TW-1:0] GUARD_END = TW'(GUARD_CYC);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);

  logic [TW-1:0]         tick_cnt_reg;
  logic [IW-1:0]         idx_reg;
  scan_state_t           state_reg;
  logic [4*N_DIGITS-1:0] disp_data_reg;
  logic [N_DIGITS-1:0]   disp_blank_reg;
  logic                  pend_reg;
  logic [4*N_DIGITS-1:0] pend_data_reg;
  logic [N_DIGITS-1:0]   pend_blank_reg;
  logic [N_DIGITS-1:0]   an_reg;
  logic [6:0]            seg_reg;
  logic                  fs_reg;

  logic [TW-1:0]         tick_inc;
  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  ld_accept;
  logic [N_DIGITS-1:0]   digit_sel;
  logic                  blank_cur;
  logic [3:0]            nibble_cur;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   an_next;
  logic [6:0]            seg_next;

  assign tick_inc   = tick_cnt_reg + 1'b1;
  assign slot_wrap  = bus.en && (tick_cnt_reg == TICK_LAST);
  assign frame_wrap = slot_wrap && (idx_reg == IDX_LAST);
  assign ld_accept  = bus.ld_valid && !pend_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_sel
      assign digit_sel[gi] = (idx_reg == IW'(gi));
    end
  endgenerate

  assign blank_cur  = |(digit_sel & disp_blank_reg);
  assign nibble_cur = disp_data_reg[{idx_reg, 2'b00} +: 4];

  // One decoder, shared by all digits through the current scan index
  seg_scan_ctrl_seg_driver u_seg_driver (
    .hex (nibble_cur),
    .seg (dec_seg)
  );

  always_comb begin
    an_next  = '1;
    seg_next = SEG_OFF;
    if (bus.en && (state_reg == DRIVE) && !blank_cur) begin
      an_next  = ~digit_sel;
      seg_next = dec_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_reg   <= '0;
      idx_reg        <= '0;
      state_reg      <= GUARD;
      disp_data_reg  <= '0;
      disp_blank_reg <= '1;
      pend_reg       <= 1'b0;
      pend_data_reg  <= '0;
      pend_blank_reg <= '0;
      an_reg         <= '1;
      seg_reg        <= SEG_OFF;
      fs_reg         <= 1'b0;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      fs_reg  <= frame_wrap;

      if (bus.en) begin
        tick_cnt_reg <= slot_wrap ? '0 : tick_inc;
        if (slot_wrap) begin
          idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
        case (state_reg)
          GUARD: if (!slot_wrap && (tick_inc == GUARD_END)) state_reg <= DRIVE;
          DRIVE: if (slot_wrap) state_reg <= GUARD;
          default: state_reg <= GUARD;
        endcase
      end

      // A load taken on the wrap itself waits for the next frame boundary
      if (frame_wrap && pend_reg) begin
        disp_data_reg  <= pend_data_reg;
        disp_blank_reg <= pend_blank_reg;
        pend_reg       <= 1'b0;
      end else if (ld_accept) begin
        pend_data_reg  <= bus.ld_data;
        pend_blank_reg <= bus.ld_blank;
        pend_reg       <= 1'b1;
      end
    end
  end

  assign bus.ld_ready    = !pend_reg;
  assign bus.AN          = an_reg;
  assign bus.SEG         = seg_reg;
  assign bus.frame_start = fs_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with N_DIGITS=4, TICK_DIV=8, GUARD_CYC=2.
module tb_seg_scan_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_ctrl_if #(.N_DIGITS(4)) bus ();

  seg_scan_ctrl #(
    .N_DIGITS  (4),
    .TICK_DIV  (8),
    .GUARD_CYC (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  int          ld1_cnt = -1;
  int          ld2_cnt = -1;
  logic [15:0] ld1_data, ld2_data;
  logic [3:0]  ld1_blank, ld2_blank;

  function automatic logic [6:0] hexseg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;
      4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;
      4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;
      4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;
      4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0011000;
      4'hA: return 7'b0001000;
      4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;
      4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic edge_with(input logic v, input logic [15:0] d, input logic [3:0] b);
    bus.ld_valid = v;
    bus.ld_data  = d;
    bus.ld_blank = b;
    @(posedge clk);
    #1;
    bus.ld_valid = 1'b0;
  endtask

  // cnt = frame position (tick + 8*digit) seen by the DUT before this edge
  task automatic step_check(input int cnt, input logic [15:0] dd, input logic [3:0] db,
                            input string tag);
    int         t;
    int         d;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    if (cnt == ld1_cnt)      edge_with(1'b1, ld1_data, ld1_blank);
    else if (cnt == ld2_cnt) edge_with(1'b1, ld2_data, ld2_blank);
    else                     edge_with(1'b0, 16'h0000, 4'h0);
    t = cnt % 8;
    d = cnt / 8;
    exp_an  = 4'b1111;
    exp_seg = 7'b1111111;
    if (t >= 2 && !db[d]) begin
      exp_an[d] = 1'b0;
      exp_seg   = hexseg(dd[d*4 +: 4]);
    end
    chk($sformatf("%s.an%0d", tag, cnt), 32'(bus.AN), 32'(exp_an));
    chk($sformatf("%s.seg%0d", tag, cnt), 32'(bus.SEG), 32'(exp_seg));
    chk($sformatf("%s.fs%0d", tag, cnt), 32'(bus.frame_start), 32'(cnt == 31));
  endtask

  task automatic run_frame(input logic [15:0] dd, input logic [3:0] db, input string tag,
                           input int exp_ready_mid);
    for (int c = 0; c < 32; c++) begin
      step_check(c, dd, db, tag);
      if (c == 15 && exp_ready_mid >= 0)
        chk({tag, ".ready_mid"}, 32'(bus.ld_ready), 32'(exp_ready_mid));
    end
    ld1_cnt = -1;
    ld2_cnt = -1;
    $display("frame %s done: data=%04h blank=%b", tag, dd, db);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.ld_blank = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.an", 32'(bus.AN), 32'h0000000F);
    chk("rst.seg", 32'(bus.SEG), 32'h0000007F);
    chk("rst.fs", 32'(bus.frame_start), 32'h0);
    chk("rst.ready", 32'(bus.ld_ready), 32'h1);
    $display("reset: AN=%b SEG=%b ready=%b", bus.AN, bus.SEG, bus.ld_ready);

    rst_n  = 1'b1;
    bus.en = 1'b1;
    run_frame(16'h0000, 4'hF, "f0", 1);

    // First load taken at frame start; a second request while pending is ignored
    ld1_cnt = 0;  ld1_data = 16'h3A0F; ld1_blank = 4'b0000;
    ld2_cnt = 9;  ld2_data = 16'h1234; ld2_blank = 4'b0000;
    run_frame(16'h0000, 4'hF, "f1", 0);
    chk("f1.ready_end", 32'(bus.ld_ready), 32'h1);

    // Load accepted exactly on the wrap edge
    ld1_cnt = 31; ld1_data = 16'h0789; ld1_blank = 4'b0100;
    run_frame(16'h3A0F, 4'b0000, "f2", 1);
    chk("f2.ready_end", 32'(bus.ld_ready), 32'h0);
    run_frame(16'h3A0F, 4'b0000, "f3", 0);
    chk("f3.ready_end", 32'(bus.ld_ready), 32'h1);
    run_frame(16'h0789, 4'b0100, "f4", 1);

    // Pause mid-DRIVE of digit 1
    for (int c = 0; c < 13; c++) step_check(c, 16'h0789, 4'b0100, "f5");
    bus.en = 1'b0;
    for (int p = 0; p < 10; p++) begin
      edge_with(1'b0, 16'h0000, 4'h0);
      chk($sformatf("pause.an%0d", p), 32'(bus.AN), 32'h0000000F);
      chk($sformatf("pause.seg%0d", p), 32'(bus.SEG), 32'h0000007F);
      chk($sformatf("pause.fs%0d", p), 32'(bus.frame_start), 32'h0);
    end
    $display("pause: 10 cycles with en=0");
    bus.en = 1'b1;
    for (int c = 13; c < 32; c++) step_check(c, 16'h0789, 4'b0100, "f5");
    $display("frame f5 resumed and done");

    // Reset mid-frame with data pending
    ld1_cnt = 0; ld1_data = 16'hFFFF; ld1_blank = 4'b0000;
    for (int c = 0; c < 20; c++) step_check(c, 16'h0789, 4'b0100, "f6");
    ld1_cnt = -1;
    chk("f6.ready_pend", 32'(bus.ld_ready), 32'h0);
    rst_n = 1'b0;
    edge_with(1'b0, 16'h0000, 4'h0);
    chk("rst2.an", 32'(bus.AN), 32'h0000000F);
    chk("rst2.seg", 32'(bus.SEG), 32'h0000007F);
    chk("rst2.fs", 32'(bus.frame_start), 32'h0);
    chk("rst2.ready", 32'(bus.ld_ready), 32'h1);
    $display("mid-frame reset: AN=%b SEG=%b ready=%b", bus.AN, bus.SEG, bus.ld_ready);
    rst_n = 1'b1;
    run_frame(16'h0000, 4'hF, "r0", 1);
    run_frame(16'h0000, 4'hF, "r1", 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
